// File: rtl/alu_pkg.sv
// Shared definitions for the RV64IM ALU: datapath width, funct3/funct7 encodings
// and a small two's-complement helper.
package alu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_base_f3_e;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } alu_md_f3_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Combinational RV64 M-extension unit (MUL*/DIV*/REM*), only instantiated by the
// top when ALU_MULDIV_EN is defined.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_result
);

  logic                  w_a_signed;
  logic                  w_b_signed;
  logic [2*XLEN-1:0]     w_a_ext;
  logic [2*XLEN-1:0]     w_b_ext;
  logic [2*XLEN-1:0]     w_prod;

  // Extending both operands to 128 bits makes the truncated product correct for
  // every signedness combination with a single multiplier.
  assign w_a_signed = (i_funct3 == F3_MULH) || (i_funct3 == F3_MULHSU);
  assign w_b_signed = (i_funct3 == F3_MULH);
  assign w_a_ext    = {{XLEN{w_a_signed & i_a[XLEN-1]}}, i_a};
  assign w_b_ext    = {{XLEN{w_b_signed & i_b[XLEN-1]}}, i_b};
  assign w_prod     = w_a_ext * w_b_ext;

  logic                  w_div_signed;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic                  w_b_zero;
  logic [XLEN-1:0]       w_dvd;
  logic [XLEN-1:0]       w_dvs;
  logic [XLEN-1:0]       w_uquo;
  logic [XLEN-1:0]       w_urem;
  logic [XLEN-1:0]       w_quo;
  logic [XLEN-1:0]       w_rem;

  // Signed division runs on magnitudes; MIN/-1 then falls out as MIN rem 0.
  assign w_div_signed = (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
  assign w_a_neg      = w_div_signed & i_a[XLEN-1];
  assign w_b_neg      = w_div_signed & i_b[XLEN-1];
  assign w_b_zero     = (i_b == '0);
  assign w_dvd        = w_a_neg ? negate(i_a) : i_a;
  assign w_dvs        = w_b_zero ? XLEN'(1) : (w_b_neg ? negate(i_b) : i_b);
  assign w_uquo       = w_dvd / w_dvs;
  assign w_urem       = w_dvd % w_dvs;
  assign w_quo        = w_b_zero ? '1  : ((w_a_neg ^ w_b_neg) ? negate(w_uquo) : w_uquo);
  assign w_rem        = w_b_zero ? i_a : (w_a_neg ? negate(w_urem) : w_urem);

  always_comb begin
    o_result = '0;
    case (i_funct3)
      F3_MUL:    o_result = w_prod[XLEN-1:0];
      F3_MULH,
      F3_MULHSU,
      F3_MULHU:  o_result = w_prod[2*XLEN-1:XLEN];
      F3_DIV,
      F3_DIVU:   o_result = w_quo;
      F3_REM,
      F3_REMU:   o_result = w_rem;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// RV64IM execute-stage ALU with combinational and registered result.
// Define ALU_MULDIV_EN to include the multiply/divide unit (funct7=0000001).
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic [XLEN-1:0] out,
  output logic [XLEN-1:0] out_q
);

  logic            w_alt;
  logic [5:0]      w_shamt;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;
  logic            w_slt;
  logic            w_sltu;
  logic            w_unused_f7;
  logic [XLEN-1:0] r_out;

  // Only funct7[5] matters in the base group; the remaining bits are ignored.
  assign w_alt       = |(funct7 & F7_ALT);
  assign w_unused_f7 = ^{funct7[6], funct7[4:0]};
  assign w_shamt     = in2[5:0];
  assign w_sum       = w_alt ? (in1 - in2) : (in1 + in2);
  assign w_slt       = $signed(in1) < $signed(in2);
  assign w_sltu      = in1 < in2;

  always_comb begin
    w_base = '0;
    case (funct3)
      F3_ADD:  w_base = w_sum;
      F3_SLL:  w_base = in1 << w_shamt;
      F3_SLT:  w_base = {{(XLEN-1){1'b0}}, w_slt};
      F3_SLTU: w_base = {{(XLEN-1){1'b0}}, w_sltu};
      F3_XOR:  w_base = in1 ^ in2;
      F3_SR:   w_base = w_alt ? $unsigned($signed(in1) >>> w_shamt) : (in1 >> w_shamt);
      F3_OR:   w_base = in1 | in2;
      F3_AND:  w_base = in1 & in2;
      default: w_base = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  logic            w_is_md;
  logic [XLEN-1:0] w_md;

  assign w_is_md = (funct7 == F7_MULDIV);

  alu_muldiv u_muldiv (
    .i_a      (in1),
    .i_b      (in2),
    .i_funct3 (funct3),
    .o_result (w_md)
  );

  assign out = w_is_md ? w_md : w_base;
`else
  assign out = w_base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out <= '0;
    else        r_out <= out;
  end

  assign out_q = r_out;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu; M-group vectors are used when ALU_MULDIV_EN
// is defined, otherwise funct7=0000001 is checked to behave as the base group.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [63:0] out;
  logic [63:0] out_q;

  int nChecks = 0;
  int nFails  = 0;

  localparam logic [6:0] BASE = 7'b0000000;
  localparam logic [6:0] ALT  = 7'b0100000;
  localparam logic [6:0] MD   = 7'b0000001;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in1    (in1),
    .in2    (in2),
    .funct3 (funct3),
    .funct7 (funct7),
    .out    (out),
    .out_q  (out_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge so the result settles well away from posedge.
  task automatic applyStimulus(input logic [2:0] f3, input logic [6:0] f7,
                               input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    funct3 = f3;
    funct7 = f7;
    in1    = a;
    in2    = b;
    #1;
  endtask

  task automatic runVec(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    applyStimulus(f3, f7, a, b);
    checkOutput(tag, out, exp);
  endtask

  initial begin
    #2;
    checkOutput("reset_out_q", out_q, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    runVec("add_wrap",     3'b000, BASE, ONES, 64'd1, 64'd0);
    runVec("sub_under",    3'b000, ALT,  64'd0, 64'd1, ONES);
    runVec("sub_8_3",      3'b000, ALT,  64'd8, 64'd3, 64'd5);
    runVec("add_f7_40",    3'b000, 7'b1000000, 64'd8, 64'd3, 64'd11);
    runVec("slt_neg",      3'b010, BASE, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'd1);
    runVec("sltu_big",     3'b011, BASE, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 64'd0);
    runVec("slt_5_3",      3'b010, BASE, 64'd5, 64'd3, 64'd0);
    runVec("sll_8",        3'b001, BASE, 64'h1234_5678_9ABC_DEF0, 64'd8, 64'h3456_789A_BCDE_F000);
    runVec("srl_4",        3'b101, BASE, MIN, 64'd4, 64'h0800_0000_0000_0000);
    runVec("sra_4",        3'b101, ALT,  MIN, 64'd4, 64'hF800_0000_0000_0000);
    runVec("sra_m1",       3'b101, ALT,  ONES, 64'd8, ONES);
    runVec("sll_amt44",    3'b001, BASE, 64'd1, 64'h44, 64'h10);
    runVec("srl_f7_1f",    3'b101, 7'b0011111, MIN, 64'd4, 64'h0800_0000_0000_0000);
    runVec("sra_f7_7f",    3'b101, 7'b1111111, MIN, 64'd4, 64'hF800_0000_0000_0000);
    runVec("xor",          3'b100, BASE, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, ONES);
    runVec("and_low",      3'b111, BASE, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_9ABC_DEF0);
    runVec("or",           3'b110, BASE, 64'hF0, 64'h0F, 64'hFF);

`ifdef ALU_MULDIV_EN
    runVec("mul",          3'b000, MD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2);
    runVec("mulh_pos",     3'b001, MD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'd0);
    runVec("mulh_neg",     3'b001, MD, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, ONES);
    runVec("mulhsu",       3'b010, MD, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, ONES);
    runVec("mulhu",        3'b011, MD, ONES, 64'd2, 64'd1);
    runVec("mulhu_3",      3'b011, MD, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'd2);
    runVec("div_neg",      3'b100, MD, 64'hFFFF_FFFF_FFFF_FFF6, 64'd2, 64'hFFFF_FFFF_FFFF_FFFB);
    runVec("div_negdvs",   3'b100, MD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
    runVec("rem",          3'b110, MD, 64'd11, 64'd3, 64'd2);
    runVec("rem_neg",      3'b110, MD, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES);
    runVec("divu",         3'b101, MD, 64'd10, 64'd2, 64'd5);
    runVec("divu_big",     3'b101, MD, ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF);
    runVec("remu",         3'b111, MD, 64'd11, 64'd3, 64'd2);
    runVec("div_zero",     3'b100, MD, 64'd5, 64'd0, ONES);
    runVec("divu_zero",    3'b101, MD, 64'd5, 64'd0, ONES);
    runVec("rem_zero",     3'b110, MD, 64'd7, 64'd0, 64'd7);
    runVec("remu_zero",    3'b111, MD, 64'd7, 64'd0, 64'd7);
    runVec("div_ovf",      3'b100, MD, MIN, ONES, MIN);
    runVec("rem_ovf",      3'b110, MD, MIN, ONES, 64'd0);
`else
    runVec("md_as_add",    3'b000, MD, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5);
    runVec("md_as_srl",    3'b101, MD, MIN, 64'd4, 64'h0800_0000_0000_0000);
    runVec("md_as_xor",    3'b100, MD, 64'hF0, 64'hFF, 64'h0F);
`endif

    // Registered copy: old value holds until the edge, new value one cycle later.
    applyStimulus(3'b000, BASE, 64'd8, 64'd3);
    @(posedge clk);
    #1;
    checkOutput("reg_add", out_q, 64'd11);
    applyStimulus(3'b100, BASE, 64'hFF00, 64'h0FF0);
    checkOutput("reg_hold", out_q, 64'd11);
    @(posedge clk);
    #1;
    checkOutput("reg_xor", out_q, 64'hF0F0);

    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_clear", out_q, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", out_q, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_reset", out_q, 64'hF0F0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
